snow64_ext_data_bridge: RTL and testbench

- Downstream consumer of one CPU external-data-access port: either the memory port or the IO port. Two instances are used, one per port.
- Takes a full-width LAR-data read/write request and splits it into a sequence of narrower external-bus beats.
- Reassembles read beats and returns the whole line to the CPU with a single-cycle valid pulse.
- Decouples the 256-bit CPU data path from the narrower system bus.

---
 rtl/snow64_ext_data_bridge_if.sv | 46 ++++
 rtl/snow64_ext_data_bridge.sv | 161 ++++++++++++++++
 tb/tb_snow64_ext_data_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_ext_data_bridge_if.sv
// Port bundles for snow64_ext_data_bridge: CPU-side LAR access port and
// narrow external bus beat port. The bridge is the slave of cpu_if and the master of bus_if.
interface snow64_ext_data_bridge_cpu_if #(
  parameter int CPU_ADDR_WIDTH = 64,
  parameter int LAR_DATA_WIDTH = 256
);
  logic                      cpu_req;
  logic                      cpu_access_type;
  logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
  logic [LAR_DATA_WIDTH-1:0] cpu_wdata;
  logic                      cpu_valid;
  logic [LAR_DATA_WIDTH-1:0] cpu_rdata;
  logic                      cpu_err;

  modport master (
    output cpu_req, cpu_access_type, cpu_addr, cpu_wdata,
    input  cpu_valid, cpu_rdata, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_access_type, cpu_addr, cpu_wdata,
    output cpu_valid, cpu_rdata, cpu_err
  );
endinterface

interface snow64_ext_data_bridge_bus_if #(
  parameter int CPU_ADDR_WIDTH = 64,
  parameter int BUS_DATA_WIDTH = 64
);
  logic                      bus_req;
  logic                      bus_we;
  logic [CPU_ADDR_WIDTH-1:0] bus_addr;
  logic [BUS_DATA_WIDTH-1:0] bus_wdata;
  logic                      bus_ack;
  logic [BUS_DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/snow64_ext_data_bridge.sv
// Splits one LAR-line CPU access into little-endian external bus beats and returns the line.
// Optional per-beat watchdog: define SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN.
module snow64_ext_data_bridge #(
  parameter int CPU_ADDR_WIDTH = 64,
  parameter int LAR_DATA_WIDTH = 256,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  snow64_ext_data_bridge_cpu_if.slave  cpu,
  snow64_ext_data_bridge_bus_if.master bus
);
  localparam int NUM_BEATS  = LAR_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LINE_BYTES = LAR_DATA_WIDTH / 8;
  localparam int BUS_BYTES  = BUS_DATA_WIDTH / 8;
  localparam logic [CPU_ADDR_WIDTH-1:0] LINE_MASK = ~CPU_ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t                    state, stateNext;
  logic [BEAT_W-1:0]         beat, beatNext;
  logic                      isWrite, isWriteNext;
  logic [CPU_ADDR_WIDTH-1:0] baseAddr, baseAddrNext;
  logic [LAR_DATA_WIDTH-1:0] lineBuf, lineBufNext;
  logic                      busReq, busReqNext;
  logic                      busWe, busWeNext;
  logic [CPU_ADDR_WIDTH-1:0] busAddr, busAddrNext;
  logic [BUS_DATA_WIDTH-1:0] busWdata, busWdataNext;
  logic                      cpuValid, cpuValidNext;
  logic [LAR_DATA_WIDTH-1:0] cpuRdata, cpuRdataNext;

`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] toCnt, toCntNext;
  logic            cpuErr, cpuErrNext;
`endif

  always_comb begin
    stateNext    = state;
    beatNext     = beat;
    isWriteNext  = isWrite;
    baseAddrNext = baseAddr;
    lineBufNext  = lineBuf;
    busReqNext   = busReq;
    busWeNext    = busWe;
    busAddrNext  = busAddr;
    busWdataNext = busWdata;
    cpuValidNext = 1'b0;
    cpuRdataNext = cpuRdata;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
    toCntNext    = toCnt;
    cpuErrNext   = cpuErr;
`endif
    unique case (state)
      IDLE: begin
        if (cpu.cpu_req) begin
          isWriteNext  = cpu.cpu_access_type;
          baseAddrNext = cpu.cpu_addr & LINE_MASK;
          lineBufNext  = cpu.cpu_wdata;
          beatNext     = '0;
          busReqNext   = 1'b1;
          busWeNext    = cpu.cpu_access_type;
          busAddrNext  = cpu.cpu_addr & LINE_MASK;
          busWdataNext = cpu.cpu_wdata[BUS_DATA_WIDTH-1:0];
          stateNext    = BEAT;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
          toCntNext    = '0;
`endif
        end
      end
      BEAT: begin
        if (busReq && bus.bus_ack) begin
          if (!isWrite)
            lineBufNext[int'(beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus.bus_rdata;
          if (beat == LAST_BEAT) begin
            busReqNext   = 1'b0;
            cpuValidNext = 1'b1;
            cpuRdataNext = lineBufNext;
            stateNext    = DONE;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
            cpuErrNext   = 1'b0;
`endif
          end else begin
            // Registered beat outputs are preloaded with the following beat so bus_req stays high.
            beatNext     = beat + BEAT_W'(1);
            busAddrNext  = baseAddr + CPU_ADDR_WIDTH'(beatNext) * CPU_ADDR_WIDTH'(BUS_BYTES);
            busWdataNext = lineBuf[int'(beatNext)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
            toCntNext    = '0;
`endif
          end
        end
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
        else if (toCnt == TO_LAST) begin
          busReqNext   = 1'b0;
          cpuValidNext = 1'b1;
          cpuRdataNext = '1;
          cpuErrNext   = 1'b1;
          stateNext    = DONE;
        end else begin
          toCntNext    = toCnt + TO_W'(1);
        end
`endif
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      isWrite  <= 1'b0;
      baseAddr <= '0;
      lineBuf  <= '0;
      busReq   <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= '0;
      busWdata <= '0;
      cpuValid <= 1'b0;
      cpuRdata <= '0;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
      toCnt    <= '0;
      cpuErr   <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      beat     <= beatNext;
      isWrite  <= isWriteNext;
      baseAddr <= baseAddrNext;
      lineBuf  <= lineBufNext;
      busReq   <= busReqNext;
      busWe    <= busWeNext;
      busAddr  <= busAddrNext;
      busWdata <= busWdataNext;
      cpuValid <= cpuValidNext;
      cpuRdata <= cpuRdataNext;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
      toCnt    <= toCntNext;
      cpuErr   <= cpuErrNext;
`endif
    end
  end

  assign bus.bus_req   = busReq;
  assign bus.bus_we    = busWe;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_wdata = busWdata;
  assign cpu.cpu_valid = cpuValid;
  assign cpu.cpu_rdata = cpuRdata;
`ifdef SNOW64_EXT_DATA_BRIDGE_TIMEOUT_EN
  assign cpu.cpu_err   = cpuErr;
`else
  assign cpu.cpu_err   = 1'b0;
`endif
endmodule

// File: tb/tb_snow64_ext_data_bridge.sv
// Bench for snow64_ext_data_bridge: bus responder with configurable ack delay, line-level reference model.
module tb_snow64_ext_data_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snow64_ext_data_bridge_cpu_if #(.CPU_ADDR_WIDTH(64), .LAR_DATA_WIDTH(256)) cpuIf ();
  snow64_ext_data_bridge_bus_if #(.CPU_ADDR_WIDTH(64), .BUS_DATA_WIDTH(64)) busIf ();

  snow64_ext_data_bridge #(
    .CPU_ADDR_WIDTH(64), .LAR_DATA_WIDTH(256), .BUS_DATA_WIDTH(64), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .cpu(cpuIf), .bus(busIf)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } beatRec_t;

  beatRec_t    beatQ[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          ackDelay = 0;
  logic        ackForce = 1'b0;
  int          waitCnt = 0;
  int          unstableCnt = 0;
  logic        holdWe;
  logic [63:0] holdAddr, holdData;
  logic [63:0] key = 64'h0;
  logic        directedOn = 1'b0;

  // Memory image: directed pattern around 0x1000 for the fixed read case, hash elsewhere.
  function automatic logic [63:0] memWord(input logic [63:0] a, input logic [63:0] k, input logic dir);
    logic [7:0] b;
    if (dir && a >= 64'h1000 && a < 64'h1020) begin
      b = 8'h11 * {6'd0, a[4:3]} + 8'h11;
      return {8{b}};
    end
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ k;
  endfunction

  function automatic logic [255:0] expLine(input logic we, input logic [63:0] addr,
                                           input logic [255:0] wdata);
    logic [255:0] r;
    logic [63:0]  base;
    base = addr & ~64'h1F;
    if (we) return wdata;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = memWord(base + 64'(i*8), key, directedOn);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  assign busIf.bus_ack   = ackForce | (busIf.bus_req & (waitCnt >= ackDelay));
  assign busIf.bus_rdata = memWord(busIf.bus_addr, key, directedOn);

  always @(posedge clk) begin
    if (busIf.bus_req) begin
      if (waitCnt > 0 && (busIf.bus_addr !== holdAddr || busIf.bus_wdata !== holdData ||
                          busIf.bus_we !== holdWe))
        unstableCnt <= unstableCnt + 1;
      holdAddr <= busIf.bus_addr;
      holdData <= busIf.bus_wdata;
      holdWe   <= busIf.bus_we;
      if (busIf.bus_ack) begin
        beatQ.push_back('{busIf.bus_we, busIf.bus_addr, busIf.bus_wdata});
        waitCnt <= 0;
      end else begin
        waitCnt <= waitCnt + 1;
      end
    end else begin
      waitCnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete CPU access; cpu_req is driven with noise while the access is in flight.
  task automatic doTxn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [255:0] wdata, input int delay, input logic ackAll);
    logic [255:0] exp;
    logic [63:0]  base;
    int           lat;
    int           u0;
    exp = expLine(we, addr, wdata);
    base = addr & ~64'h1F;
    ackDelay = delay;
    ackForce = ackAll;
    beatQ.delete();
    u0 = unstableCnt;
    cpuIf.cpu_req = 1'b1;
    cpuIf.cpu_access_type = we;
    cpuIf.cpu_addr = addr;
    cpuIf.cpu_wdata = wdata;
    lat = 0;
    do begin
      tick();
      lat++;
      cpuIf.cpu_req = 1'($urandom_range(0, 1));
      cpuIf.cpu_access_type = 1'($urandom_range(0, 1));
      cpuIf.cpu_addr = {$urandom, $urandom};
      cpuIf.cpu_wdata = rand256();
    end while (!cpuIf.cpu_valid && lat < 200);
    cpuIf.cpu_req = 1'b0;
    chk({tag, ".valid"}, cpuIf.cpu_valid, 1);
    chk({tag, ".latency"}, lat, ackAll ? 5 : 4 * delay + 5);
    chk({tag, ".rdata"}, cpuIf.cpu_rdata, exp);
    chk({tag, ".err"}, cpuIf.cpu_err, 0);
    chk({tag, ".nbeats"}, beatQ.size(), 4);
    for (int i = 0; i < 4 && i < beatQ.size(); i++) begin
      chk({tag, ".we"}, beatQ[i].we, we);
      chk({tag, ".addr"}, beatQ[i].addr, base + 64'(i*8));
      if (we) chk({tag, ".wdata"}, beatQ[i].wdata, wdata[i*64 +: 64]);
    end
    chk({tag, ".stable"}, unstableCnt - u0, 0);
    tick();
    chk({tag, ".pulse"}, cpuIf.cpu_valid, 0);
    chk({tag, ".hold"}, cpuIf.cpu_rdata, exp);
    chk({tag, ".busidle"}, busIf.bus_req, 0);
  endtask

  initial begin
    logic [255:0] w;
    logic [255:0] e;
    logic [63:0]  a;
    int           lat, v1, v2, seen;

    cpuIf.cpu_req = 1'b0;
    cpuIf.cpu_access_type = 1'b0;
    cpuIf.cpu_addr = '0;
    cpuIf.cpu_wdata = '0;
    key = {$urandom, $urandom};
    repeat (3) tick();
    chk("rst.valid", cpuIf.cpu_valid, 0);
    chk("rst.rdata", cpuIf.cpu_rdata, 0);
    chk("rst.err", cpuIf.cpu_err, 0);
    chk("rst.req", busIf.bus_req, 0);
    chk("rst.we", busIf.bus_we, 0);
    chk("rst.addr", busIf.bus_addr, 0);
    chk("rst.wdata", busIf.bus_wdata, 0);
    rst = 1'b0;
    tick();

    directedOn = 1'b1;
    doTxn("rd1000", 1'b0, 64'h1000, '0, 0, 1'b0);
    chk("rd1000.lit", cpuIf.cpu_rdata,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    directedOn = 1'b0;

    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(i);
    doTxn("wr2017", 1'b1, 64'h2017, w, 0, 1'b0);
    chk("wr2017.b0addr", beatQ[0].addr, 64'h2000);
    chk("wr2017.b0data", beatQ[0].wdata, 64'h0706_0504_0302_0100);

    doTxn("rddly3", 1'b0, {$urandom, $urandom}, '0, 3, 1'b0);
    doTxn("wrdly3", 1'b1, {$urandom, $urandom}, rand256(), 3, 1'b0);
    doTxn("ackall", 1'b0, {$urandom, $urandom}, '0, 0, 1'b1);
    doTxn("top", 1'b0, 64'hFFFF_FFFF_FFFF_FFF3, '0, 1, 1'b0);

    for (int i = 0; i < 20; i++)
      doTxn("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom}, rand256(),
            $urandom_range(0, 3), 1'b0);

    // Held request: second access starts the cycle after the first completion.
    a = {$urandom, $urandom};
    e = expLine(1'b0, a, '0);
    ackDelay = 0;
    ackForce = 1'b0;
    beatQ.delete();
    cpuIf.cpu_req = 1'b1;
    cpuIf.cpu_access_type = 1'b0;
    cpuIf.cpu_addr = a;
    lat = 0; v1 = 0; v2 = 0;
    while (v2 == 0 && lat < 100) begin
      tick();
      lat++;
      if (cpuIf.cpu_valid) begin
        if (v1 == 0) v1 = lat;
        else v2 = lat;
        chk("held.rdata", cpuIf.cpu_rdata, e);
      end
    end
    cpuIf.cpu_req = 1'b0;
    chk("held.first", v1, 5);
    chk("held.second", v2, 11);
    chk("held.nbeats", beatQ.size(), 8);
    tick();

    // Reset while beat 2 is on the bus.
    a = {$urandom, $urandom};
    beatQ.delete();
    cpuIf.cpu_req = 1'b1;
    cpuIf.cpu_access_type = 1'b0;
    cpuIf.cpu_addr = a;
    tick();
    cpuIf.cpu_req = 1'b0;
    tick();
    tick();
    chk("rstmid.beat2", busIf.bus_addr, (a & ~64'h1F) + 64'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.req", busIf.bus_req, 0);
    chk("rstmid.rdata", cpuIf.cpu_rdata, 0);
    seen = 0;
    repeat (8) begin
      tick();
      if (cpuIf.cpu_valid) seen++;
    end
    chk("rstmid.novalid", seen, 0);
    chk("rstmid.idle", busIf.bus_req, 0);
    doTxn("afterrst", 1'b0, {$urandom, $urandom}, '0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
